// File: rtl/pixel_histogram.sv
// Camera pixel histogram: bins one pixel per cycle through a forwarding read-modify-write
// pipeline, then streams every bin out over a valid/ready port, clearing each bin as it goes.
module pixel_histogram #(
    parameter int unsigned PIXEL_WIDTH = 10,
    parameter int unsigned BIN_BITS    = 10,
    parameter int unsigned COUNT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic                   frame_valid,
    input  logic                   line_valid,
    input  logic [PIXEL_WIDTH-1:0] pixel_data,
    output logic                   hist_valid,
    input  logic                   hist_ready,
    output logic [BIN_BITS-1:0]    hist_bin,
    output logic [COUNT_WIDTH-1:0] hist_data,
    output logic                   hist_last,
    output logic                   busy,
    output logic [7:0]             dropped_frames
);

    localparam int unsigned            NumBins  = 2 ** BIN_BITS;
    localparam logic [BIN_BITS-1:0]    LastBin  = {BIN_BITS{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] CountMax = {COUNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StDrain,
        StDump,
        StSync
    } state_e;

    state_e state_q, state_d;

    logic fv_q;
    logic fv_rise, fv_fall;

    logic                init_q, init_d;
    logic                sweep_q, sweep_d;
    logic [BIN_BITS-1:0] sweep_addr_q, sweep_addr_d;
    logic [1:0]          drain_cnt_q, drain_cnt_d;
    logic [7:0]          dropped_q, dropped_d;

    logic start_frame;
    logic pix_acc;

    logic                   s1_vld_q;
    logic [BIN_BITS-1:0]    s1_bin_q;
    logic                   s2_vld_q;
    logic [BIN_BITS-1:0]    s2_bin_q;
    logic                   wb_vld_q;
    logic [BIN_BITS-1:0]    wb_bin_q;
    logic [COUNT_WIDTH-1:0] wb_cnt_q;
    logic [COUNT_WIDTH-1:0] cnt_old, cnt_new;

    logic [COUNT_WIDTH-1:0] mem [NumBins];
    logic [COUNT_WIDTH-1:0] rd_data_q;
    logic                   rd_en;
    logic [BIN_BITS-1:0]    rd_addr;
    logic                   wr_en;
    logic [BIN_BITS-1:0]    wr_addr;
    logic [COUNT_WIDTH-1:0] wr_data;

    logic [BIN_BITS:0]   dump_cnt_q, dump_cnt_d;
    logic [BIN_BITS-1:0] dump_addr;
    logic                hist_valid_q, hist_valid_d;
    logic                hist_last_q, hist_last_d;
    logic [BIN_BITS-1:0] hist_bin_q, hist_bin_d;
    logic                load, xfer, last_xfer;

    assign fv_rise   = frame_valid & ~fv_q;
    assign fv_fall   = ~frame_valid & fv_q;
    assign dump_addr = dump_cnt_q[BIN_BITS-1:0];

    assign start_frame = (state_q == StIdle) && init_q && !sweep_q && fv_rise && en;
    assign pix_acc     = frame_valid && line_valid && ((state_q == StAccum) || start_frame);

    assign xfer      = hist_valid_q && hist_ready;
    assign last_xfer = xfer && hist_last_q;
    assign load      = (state_q == StDump) && !dump_cnt_q[BIN_BITS] && (!hist_valid_q || hist_ready);

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // A frame already in flight at the first clock, or one that starts while
                // the RAM is still being cleared, is partial: wait it out.
                if (!init_q) begin
                    state_d = frame_valid ? StSync : StIdle;
                end else if (fv_rise && en) begin
                    state_d = sweep_q ? StSync : StAccum;
                end
            end
            StAccum: if (fv_fall) state_d = StDrain;
            StDrain: if (drain_cnt_q == 2'd2) state_d = StDump;
            StDump:  if (last_xfer) state_d = frame_valid ? StSync : StIdle;
            StSync:  if (!frame_valid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        busy           = (state_q != StIdle) || sweep_q;
        hist_valid     = hist_valid_q;
        hist_bin       = hist_bin_q;
        hist_last      = hist_last_q;
        hist_data      = hist_valid_q ? rd_data_q : '0;
        dropped_frames = dropped_q;
    end

    // ---------------------------------------------------------------- control next state
    always_comb begin
        init_d       = 1'b1;
        sweep_d      = sweep_q;
        sweep_addr_d = sweep_addr_q;
        if (!init_q) begin
            sweep_d      = 1'b1;
            sweep_addr_d = '0;
        end else if (sweep_q) begin
            sweep_addr_d = sweep_addr_q + 1'b1;
            if (sweep_addr_q == LastBin) sweep_d = 1'b0;
        end

        drain_cnt_d = (state_q == StDrain) ? drain_cnt_q + 2'd1 : 2'd0;

        dropped_d = dropped_q;
        if ((state_q == StDrain || state_q == StDump) && fv_rise && en && dropped_q != 8'hFF) begin
            dropped_d = dropped_q + 8'd1;
        end

        dump_cnt_d   = dump_cnt_q;
        hist_valid_d = hist_valid_q;
        hist_bin_d   = hist_bin_q;
        hist_last_d  = hist_last_q;
        if (state_q != StDump) begin
            dump_cnt_d = '0;
        end
        if (load) begin
            dump_cnt_d   = dump_cnt_q + 1'b1;
            hist_valid_d = 1'b1;
            hist_bin_d   = dump_addr;
            hist_last_d  = (dump_addr == LastBin);
        end else if (xfer) begin
            hist_valid_d = 1'b0;
            hist_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fv_q         <= 1'b0;
            init_q       <= 1'b0;
            sweep_q      <= 1'b0;
            sweep_addr_q <= '0;
            drain_cnt_q  <= 2'd0;
            dropped_q    <= 8'd0;
            dump_cnt_q   <= '0;
            hist_valid_q <= 1'b0;
            hist_bin_q   <= '0;
            hist_last_q  <= 1'b0;
        end else begin
            fv_q         <= frame_valid;
            init_q       <= init_d;
            sweep_q      <= sweep_d;
            sweep_addr_q <= sweep_addr_d;
            drain_cnt_q  <= drain_cnt_d;
            dropped_q    <= dropped_d;
            dump_cnt_q   <= dump_cnt_d;
            hist_valid_q <= hist_valid_d;
            hist_bin_q   <= hist_bin_d;
            hist_last_q  <= hist_last_d;
        end
    end

    // ---------------------------------------------------------------- RMW pipeline
    // The write of the previous pixel lands on the same edge as this pixel's read, so
    // the read misses it; the write-back register supplies that value instead.
    always_comb begin
        cnt_old = (wb_vld_q && (wb_bin_q == s2_bin_q)) ? wb_cnt_q : rd_data_q;
        cnt_new = (cnt_old == CountMax) ? cnt_old : cnt_old + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q <= 1'b0;
            s1_bin_q <= '0;
            s2_vld_q <= 1'b0;
            s2_bin_q <= '0;
            wb_vld_q <= 1'b0;
            wb_bin_q <= '0;
            wb_cnt_q <= '0;
        end else begin
            s1_vld_q <= pix_acc;
            s1_bin_q <= pixel_data[PIXEL_WIDTH-1 -: BIN_BITS];
            s2_vld_q <= s1_vld_q;
            s2_bin_q <= s1_bin_q;
            wb_vld_q <= s2_vld_q;
            wb_bin_q <= s2_bin_q;
            wb_cnt_q <= cnt_new;
        end
    end

    // ---------------------------------------------------------------- bin RAM ports
    // Sweep, readout clear and pipeline writes never overlap in time.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (sweep_q) begin
            wr_en   = 1'b1;
            wr_addr = sweep_addr_q;
        end else if (xfer) begin
            wr_en   = 1'b1;
            wr_addr = hist_bin_q;
        end else if (s2_vld_q) begin
            wr_en   = 1'b1;
            wr_addr = s2_bin_q;
            wr_data = cnt_new;
        end
        rd_en   = load || s1_vld_q;
        rd_addr = (state_q == StDump) ? dump_addr : s1_bin_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

endmodule

// File: tb/tb_pixel_histogram.sv
// Randomized bench for pixel_histogram: drives frames, keeps a per-bin count model
// and checks every readout beat against it.
module tb_pixel_histogram;

    localparam int PW    = 10;
    localparam int BB    = 10;
    localparam int CW    = 5;  // narrow counters so saturation is reachable quickly
    localparam int NBINS = 1 << BB;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          frame_valid = 1'b0;
    logic          line_valid = 1'b0;
    logic [PW-1:0] pixel_data = '0;
    logic          hist_ready = 1'b0;
    logic          hist_valid;
    logic [BB-1:0] hist_bin;
    logic [CW-1:0] hist_data;
    logic          hist_last;
    logic          busy;
    logic [7:0]    dropped_frames;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt[NBINS];
    int pix_q[$];
    int sum;

    always #5 clk = ~clk;

    pixel_histogram #(
        .PIXEL_WIDTH(PW),
        .BIN_BITS   (BB),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .frame_valid   (frame_valid),
        .line_valid    (line_valid),
        .pixel_data    (pixel_data),
        .hist_valid    (hist_valid),
        .hist_ready    (hist_ready),
        .hist_bin      (hist_bin),
        .hist_data     (hist_data),
        .hist_last     (hist_last),
        .busy          (busy),
        .dropped_frames(dropped_frames)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic clear_model();
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
    endtask

    task automatic add_pixel(input int p);
        int b;
        b = p >> (PW - BB);
        if (exp_cnt[b] < CMAX) exp_cnt[b]++;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", busy, 0);
    endtask

    // Frame of h lines of w pixels taken from pix_q; 2 blank cycles after each line.
    task automatic send_frame(input int h, input int w, input bit learn);
        @(negedge clk);
        frame_valid = 1'b1;
        line_valid  = 1'b0;
        @(negedge clk);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                line_valid = 1'b1;
                pixel_data = PW'(pix_q.pop_front());
                if (learn) add_pixel(int'(pixel_data));
                @(negedge clk);
            end
            line_valid = 1'b0;
            pixel_data = PW'($urandom);
            @(negedge clk);
            @(negedge clk);
        end
        frame_valid = 1'b0;
    endtask

    task automatic measure_latency();
        int lat = 0;
        @(posedge clk);
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (hist_valid) break;
        end
        check("latency", lat, 4);
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic collect_dump(input int mode, output int total);
        int            nxt = 0;
        int            cyc = 0;
        bit            stalled = 1'b0;
        logic [BB-1:0] pb = '0;
        logic [CW-1:0] pd = '0;
        total = 0;
        while (nxt < NBINS && cyc < 5000) begin
            @(negedge clk);
            case (mode)
                0:       hist_ready = 1'b1;
                1:       hist_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: hist_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
            if (stalled) begin
                check("stall_valid", hist_valid, 1);
                check("stall_bin", hist_bin, pb);
                check("stall_data", hist_data, pd);
            end
            stalled = 1'b0;
            if (hist_valid) begin
                if (hist_ready) begin
                    check("bin", hist_bin, nxt);
                    check("data", hist_data, exp_cnt[nxt]);
                    check("last", hist_last, (nxt == NBINS - 1));
                    total += int'(hist_data);
                    exp_cnt[nxt] = 0;
                    nxt++;
                end else begin
                    stalled = 1'b1;
                    pb      = hist_bin;
                    pd      = hist_data;
                end
            end
        end
        check("beats", nxt, NBINS);
        @(negedge clk);
        hist_ready = 1'b0;
        check("valid_after", hist_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[8];
        int prev;
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_valid", hist_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", dropped_frames, 0);
        check("rst_bin", hist_bin, 0);
        check("rst_data", hist_data, 0);
        check("rst_last", hist_last, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("sweep_busy", busy, 1);
        wait_idle(1500);
        en = 1'b1;

        // 4x4 of 0x155
        repeat (16) pix_q.push_back('h155);
        send_frame(4, 4, 1'b1);
        measure_latency();
        collect_dump(0, sum);
        check("t1_sum", sum, 16);
        wait_idle(10);

        // forwarding run
        pix_q = '{5, 5, 5, 7, 5};
        send_frame(1, 5, 1'b1);
        collect_dump(0, sum);
        check("t2_sum", sum, 5);
        wait_idle(10);

        // gradient frame
        for (int i = 0; i < 64 * 32; i++) pix_q.push_back(i % NBINS);
        send_frame(32, 64, 1'b1);
        collect_dump(2, sum);
        check("grad_sum", sum, 64 * 32);
        wait_idle(10);

        // few random values with runs, including a saturating run
        foreach (vals[i]) vals[i] = $urandom_range(0, NBINS - 1);
        repeat (40) pix_q.push_back(vals[0]);
        prev = vals[1];
        for (int i = 40; i < 12 * 24; i++) begin
            if ($urandom_range(0, 1) == 1) prev = vals[$urandom_range(0, 7)];
            pix_q.push_back(prev);
        end
        send_frame(12, 24, 1'b1);
        collect_dump(1, sum);
        wait_idle(10);

        // en low: frame ignored, not counted as dropped
        en = 1'b0;
        repeat (16) pix_q.push_back(9);
        send_frame(4, 4, 1'b0);
        check("en0_busy", busy, 0);
        check("en0_drop", dropped_frames, 0);
        en = 1'b1;
        repeat (4) pix_q.push_back(100);
        send_frame(2, 2, 1'b1);
        collect_dump(0, sum);
        check("en1_sum", sum, 4);
        wait_idle(10);

        // second frame starts mid-readout and outlasts it
        for (int i = 0; i < 64; i++) pix_q.push_back($urandom_range(0, NBINS - 1));
        send_frame(8, 8, 1'b1);
        for (int i = 0; i < 40 * 32; i++) pix_q.push_back($urandom_range(0, NBINS - 1));
        fork
            begin
                collect_dump(0, sum);
                check("sync_busy", busy, 1);
            end
            begin
                repeat (100) @(negedge clk);
                send_frame(40, 32, 1'b0);
            end
        join
        check("drop_one", dropped_frames, 1);
        wait_idle(10);
        for (int i = 0; i < 64; i++) pix_q.push_back($urandom_range(0, 15));
        send_frame(8, 8, 1'b1);
        collect_dump(0, sum);
        check("after_drop_sum", sum, 64);
        wait_idle(10);

        // many short dropped frames during one readout
        repeat (4) pix_q.push_back(2);
        send_frame(2, 2, 1'b1);
        fork
            collect_dump(2, sum);
            begin
                repeat (20) @(negedge clk);
                for (int i = 0; i < 300; i++) begin
                    frame_valid = 1'b1;
                    @(negedge clk);
                    @(negedge clk);
                    frame_valid = 1'b0;
                    @(negedge clk);
                end
            end
        join
        check("drop_sat", dropped_frames, 255);
        wait_idle(10);

        // reset in the middle of accumulation
        for (int i = 0; i < 8 * 16; i++) pix_q.push_back($urandom_range(0, NBINS - 1));
        fork
            send_frame(8, 16, 1'b0);
            begin
                repeat (40) @(negedge clk);
                reset_n = 1'b0;
                #2;
                check("arst_valid", hist_valid, 0);
                check("arst_busy", busy, 0);
                check("arst_drop", dropped_frames, 0);
                check("arst_bin", hist_bin, 0);
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                check("arst_sync", busy, 1);
            end
        join
        clear_model();
        wait_idle(1500);
        check("arst_nodrop", dropped_frames, 0);
        repeat (4) pix_q.push_back(3);
        send_frame(2, 2, 1'b1);
        collect_dump(0, sum);
        check("arst_sum", sum, 4);
        wait_idle(10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
